// File: rtl/side_ch_rec_arb.sv
// Round-robin record arbiter for the side-channel FIFO write port.
// Each grant writes one whole record: a timestamped header word, then len payload words.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | pick the next eligible requester (enabled, nonzero len, fits)
// ST_HDR  | write the header word once the FIFO is not full
// ST_DATA | forward payload words from the granted requester
// ST_DONE | one-cycle record close: start pulse, count, rotate priority
module side_ch_rec_arb #(
  parameter int NUM_REQ                = 2,
  parameter int C_M_AXIS_TDATA_WIDTH   = 64,
  parameter int MAX_NUM_DMA_SYMBOL     = 8192,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        arb_en,
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [NUM_REQ*MAX_BIT_NUM_DMA_SYMBOL-1:0]   req_len,
  input  logic [NUM_REQ*C_M_AXIS_TDATA_WIDTH-1:0]     src_data,
  input  logic [NUM_REQ-1:0]                          src_valid,
  output logic [NUM_REQ-1:0]                          src_ask,
  output logic [NUM_REQ-1:0]                          grant,
  input  logic [63:0]                                 tsf_runtime_val,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]           m_axis_data_count,
  input  logic                                        fulln_to_pl,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]             data_to_ps,
  output logic                                        data_to_ps_valid,
  output logic                                        m_axis_start_1trans,
  output logic [31:0]                                 rec_cnt
);

  localparam int LW = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int SW = LW + 1;
  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SW-1:0] FIT_LIM = SW'(MAX_NUM_DMA_SYMBOL);
  localparam logic [SW-1:0] ONE_S   = SW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [LW-1:0]       remain_q, remain_d;
  logic [LW-1:0]       len_q, len_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DW-1:0]       data_q, data_d;
  logic                valid_q, valid_d;
  logic                start_q, start_d;
  logic [31:0]         rec_cnt_q, rec_cnt_d;

  logic [NUM_REQ-1:0]  elig;
  logic [LW-1:0]       len_arr [NUM_REQ];
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [LW-1:0]       pick_len;
  logic [DW-1:0]       sel_data;
  logic                sel_valid;
  logic                accept;
  logic [63:0]         hdr_word;
  logic                unused_tsf_hi;

  assign unused_tsf_hi = ^tsf_runtime_val[63:32];

  // Fit check is one bit wider than the count so count+len+1 cannot wrap.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
    logic [SW-1:0] fit_sum;
    assign len_arr[g] = req_len[g*LW +: LW];
    assign fit_sum    = {1'b0, m_axis_data_count} + {1'b0, len_arr[g]} + ONE_S;
    assign elig[g]    = arb_en & req[g] & (len_arr[g] != '0) & (fit_sum <= FIT_LIM);
  end

  // Round robin: first eligible index above last_grant, else wrap from 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && elig[i] && (IW'(i) > last_grant_q)) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
        pick_len   = len_arr[i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && elig[i] && (IW'(i) <= last_grant_q)) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
        pick_len   = len_arr[i];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    src_ask   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == sel_q) begin
        sel_data   = src_data[i*DW +: DW];
        sel_valid  = src_valid[i];
        src_ask[i] = (state_q == ST_DATA) & fulln_to_pl;
      end
    end
  end

  assign accept   = (state_q == ST_DATA) & fulln_to_pl & sel_valid;
  assign hdr_word = {8'hA5, 5'd0, 3'(sel_q), 16'(len_q), tsf_runtime_val[31:0]};

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    remain_d     = remain_q;
    len_d        = len_q;
    grant_d      = grant_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    start_d      = 1'b0;
    rec_cnt_d    = rec_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          sel_d    = pick_idx;
          remain_d = pick_len;
          len_d    = pick_len;
          grant_d  = NUM_REQ'(1) << pick_idx;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (fulln_to_pl) begin
          valid_d = 1'b1;
          data_d  = DW'(hdr_word);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          valid_d  = 1'b1;
          data_d   = sel_data;
          remain_d = remain_q - 1'b1;
          if (remain_q == LW'(1)) begin
            start_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rec_cnt_d    = rec_cnt_q + 32'd1;
        last_grant_d = sel_q;
        grant_d      = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      remain_q     <= '0;
      len_q        <= '0;
      grant_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      rec_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      remain_q     <= remain_d;
      len_q        <= len_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      rec_cnt_q    <= rec_cnt_d;
    end
  end

  assign grant               = grant_q;
  assign data_to_ps          = data_q;
  assign data_to_ps_valid    = valid_q;
  assign m_axis_start_1trans = start_q;
  assign rec_cnt             = rec_cnt_q;

endmodule

// File: tb/tb_side_ch_rec_arb.sv
// Directed bench for side_ch_rec_arb: records, round robin, FIFO-space hold,
// back-pressure, zero length, disable and mid-record reset.
module tb_side_ch_rec_arb;

  localparam int NR = 2;
  localparam int LW = 14;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic              arb_en;
  logic [NR-1:0]     req;
  logic [NR*LW-1:0]  req_len;
  logic [NR*DW-1:0]  src_data;
  logic [NR-1:0]     src_valid;
  logic [NR-1:0]     src_ask;
  logic [NR-1:0]     grant;
  logic [63:0]       tsf;
  logic [LW-1:0]     dcount;
  logic              fulln;
  logic [DW-1:0]     data_to_ps;
  logic              data_to_ps_valid;
  logic              start;
  logic [31:0]       rec_cnt;

  side_ch_rec_arb #(
    .NUM_REQ(NR), .C_M_AXIS_TDATA_WIDTH(DW),
    .MAX_NUM_DMA_SYMBOL(8192), .MAX_BIT_NUM_DMA_SYMBOL(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .arb_en(arb_en), .req(req), .req_len(req_len),
    .src_data(src_data), .src_valid(src_valid), .src_ask(src_ask), .grant(grant),
    .tsf_runtime_val(tsf), .m_axis_data_count(dcount), .fulln_to_pl(fulln),
    .data_to_ps(data_to_ps), .data_to_ps_valid(data_to_ps_valid),
    .m_axis_start_1trans(start), .rec_cnt(rec_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  int idx [NR];
  int rec_left [NR];
  logic [LW-1:0] len_v [NR];
  bit gap_mode = 0;
  bit bp_mode  = 0;
  logic [63:0] tsf_old;
  logic [63:0] wr_log [$];
  logic [31:0] wr_tsf [$];
  logic [NR-1:0] gnt_log [$];
  logic [NR-1:0] grant_prev;
  logic [63:0] exp_q [$];
  bit exp_hdr [$];
  int n_start, n_start_v, ask_bad;
  int first_g, first_v, start_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int s, input int n);
    return {8'hD0 + 8'(s), 24'h0, 32'(n)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i]              = (rec_left[i] != 0);
      req_len[i*LW +: LW] = len_v[i];
      src_data[i*DW +: DW] = wd(i, idx[i]);
      src_valid[i]        = gap_mode ? ((ncyc % 3) != 0) : 1'b1;
    end
    fulln = bp_mode ? ~fulln : 1'b1;
  endtask

  task automatic cyc();
    logic [NR-1:0] acc;
    @(negedge clk);
    if (data_to_ps_valid) begin
      wr_log.push_back(data_to_ps);
      wr_tsf.push_back(tsf_old[31:0]);
      if (first_v < 0) first_v = ncyc;
    end
    if (grant != '0 && first_g < 0) first_g = ncyc;
    if (start) begin
      n_start++;
      start_c = ncyc;
      if (data_to_ps_valid) n_start_v++;
      for (int i = 0; i < NR; i++)
        if (grant[i] && rec_left[i] > 0) rec_left[i]--;
    end
    if (grant != grant_prev && grant != '0) gnt_log.push_back(grant);
    grant_prev = grant;
    if ((src_ask & ~grant) != '0) ask_bad++;
    acc = src_ask & src_valid;
    @(posedge clk);
    #2;
    ncyc++;
    for (int i = 0; i < NR; i++)
      if (acc[i]) idx[i]++;
    tsf_old = tsf;
    tsf     = tsf + 64'h0000_0001_0000_0003;
    drive();
  endtask

  task automatic clear_logs();
    wr_log.delete(); wr_tsf.delete(); gnt_log.delete();
    exp_q.delete(); exp_hdr.delete();
    for (int i = 0; i < NR; i++) idx[i] = 0;
    n_start = 0; n_start_v = 0; ask_bad = 0;
    first_g = -1; first_v = -1; start_c = -1;
  endtask

  task automatic add_rec(input int s, input int len, input int first);
    exp_q.push_back({8'hA5, 5'd0, 3'(s), 16'(len), 32'h0});
    exp_hdr.push_back(1'b1);
    for (int j = 0; j < len; j++) begin
      exp_q.push_back(wd(s, first + j));
      exp_hdr.push_back(1'b0);
    end
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      chk($sformatf("%s[%0d]", tag, k), wr_log[k],
          exp_hdr[k] ? {exp_q[k][63:32], wr_tsf[k]} : exp_q[k]);
  endtask

  task automatic run_until(input logic [31:0] target, input int budget, input string tag);
    int n = 0;
    while (rec_cnt != target && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 64'(rec_cnt), 64'(target));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_ask"},   64'(src_ask), 64'(0));
    chk({tag, "_data"},  data_to_ps, 64'(0));
    chk({tag, "_valid"}, 64'(data_to_ps_valid), 64'(0));
    chk({tag, "_start"}, 64'(start), 64'(0));
    chk({tag, "_cnt"},   64'(rec_cnt), 64'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0; arb_en = 1'b1; fulln = 1'b1; dcount = '0;
    tsf = 64'h0000_1000_0000_0100; tsf_old = tsf;
    grant_prev = '0;
    for (int i = 0; i < NR; i++) begin
      rec_left[i] = 0; len_v[i] = '0;
    end
    clear_logs();
    drive();

    // Reset values, then a single 3-word record from requester 0
    do_reset();
    chk_zero("rst");
    rec_left[0] = 1; len_v[0] = 14'd3;
    drive();
    run_until(32'd1, 40, "t1_rec_cnt");
    repeat (3) cyc();
    add_rec(0, 3, 0);
    chk_stream("t1_wr");
    chk("t1_ngrant", 64'(gnt_log.size()), 64'(1));
    if (gnt_log.size() > 0) chk("t1_grant", 64'(gnt_log[0]), 64'(2'b01));
    chk("t1_start_with_valid", 64'(n_start_v), 64'(1));
    chk("t1_hdr_lat", 64'(first_v - first_g), 64'(1));
    chk("t1_start_pos", 64'(start_c - first_v), 64'(3));

    // Round robin with both requesters, two records each
    do_reset();
    clear_logs();
    rec_left[0] = 2; rec_left[1] = 2; len_v[0] = 14'd2; len_v[1] = 14'd2;
    drive();
    run_until(32'd4, 80, "t2_rec_cnt");
    repeat (3) cyc();
    chk("t2_ngrant", 64'(gnt_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      chk($sformatf("t2_grant[%0d]", k), 64'(gnt_log[k]), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
    add_rec(0, 2, 0); add_rec(1, 2, 0); add_rec(0, 2, 2); add_rec(1, 2, 2);
    chk_stream("t2_wr");
    chk("t2_ask_only_granted", 64'(ask_bad), 64'(0));

    // FIFO space: 8190+2+1 does not fit, 8190+1+1 does; then 8189+2+1 fits exactly
    clear_logs();
    dcount = 14'd8190;
    rec_left[0] = 1; rec_left[1] = 1; len_v[0] = 14'd1; len_v[1] = 14'd2;
    drive();
    run_until(32'd5, 40, "t3_rec_cnt_a");
    repeat (20) cyc();
    chk("t3_rec_cnt_hold", 64'(rec_cnt), 64'(5));
    chk("t3_ngrant_a", 64'(gnt_log.size()), 64'(1));
    if (gnt_log.size() > 0) chk("t3_grant_a", 64'(gnt_log[0]), 64'(2'b01));
    dcount = 14'd8189;
    run_until(32'd6, 40, "t3_rec_cnt_b");
    repeat (2) cyc();
    chk("t3_ngrant_b", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() > 1) chk("t3_grant_b", 64'(gnt_log[1]), 64'(2'b10));
    add_rec(0, 1, 0); add_rec(1, 2, 0);
    chk_stream("t3_wr");
    dcount = '0;

    // Back-pressure toggling every cycle and gaps on src_valid
    do_reset();
    clear_logs();
    bp_mode = 1; gap_mode = 1;
    rec_left[0] = 1; len_v[0] = 14'd4;
    drive();
    run_until(32'd1, 80, "t4_rec_cnt");
    bp_mode = 0; gap_mode = 0;
    repeat (4) cyc();
    add_rec(0, 4, 0);
    chk_stream("t4_wr");
    chk("t4_nstart", 64'(n_start), 64'(1));
    chk("t4_start_with_valid", 64'(n_start_v), 64'(1));

    // Zero length never granted; arb_en drop during DATA lets the record finish
    do_reset();
    clear_logs();
    rec_left[0] = 1; len_v[0] = '0;
    drive();
    repeat (30) cyc();
    chk("t5_zero_ngrant", 64'(gnt_log.size()), 64'(0));
    chk("t5_zero_nwr", 64'(wr_log.size()), 64'(0));
    chk("t5_zero_cnt", 64'(rec_cnt), 64'(0));
    rec_left[0] = 0; rec_left[1] = 100; len_v[1] = 14'd3;
    drive();
    n = 0;
    while (src_ask == '0 && n < 20) begin
      cyc();
      n++;
    end
    chk("t5_reach_data", 64'(src_ask), 64'(2'b10));
    arb_en = 1'b0;
    run_until(32'd1, 40, "t5_rec_cnt");
    repeat (20) cyc();
    chk("t5_cnt_after_dis", 64'(rec_cnt), 64'(1));
    chk("t5_grant_after_dis", 64'(grant), 64'(0));
    chk("t5_ngrant", 64'(gnt_log.size()), 64'(1));
    add_rec(1, 3, 0);
    chk_stream("t5_wr");

    // Reset after 2 of 5 payload words; requester 0 must win first afterwards
    clear_logs();
    arb_en = 1'b1;
    rec_left[0] = 1; rec_left[1] = 1; len_v[0] = 14'd5; len_v[1] = 14'd5;
    drive();
    n = 0;
    while (idx[0] < 2 && n < 30) begin
      cyc();
      n++;
    end
    chk("t6_two_words", 64'(idx[0]), 64'(2));
    rstn = 1'b0;
    #1;
    chk_zero("t6_rst");
    clear_logs();
    repeat (3) cyc();
    chk("t6_nwr_in_rst", 64'(wr_log.size()), 64'(0));
    rstn = 1'b1;
    chk("t6_cnt_restart", 64'(rec_cnt), 64'(0));
    run_until(32'd1, 40, "t6_rec_cnt_a");
    run_until(32'd2, 40, "t6_rec_cnt_b");
    repeat (3) cyc();
    chk("t6_ngrant", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() > 0) chk("t6_first_grant", 64'(gnt_log[0]), 64'(2'b01));
    add_rec(0, 5, 0); add_rec(1, 5, 0);
    chk_stream("t6_wr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
